// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, writeback result sources
// and load funct3 encodings.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/half out of an aligned
// memory word, sign/zero-extends it, and flags misaligned halfword/word loads.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = word[gi*8 +: 8];
        end
    endgenerate

    assign byte_sel = byte_lane[offset];
    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data       = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = offset[0];
            end
            // lw and any unlisted encoding: whole word, must be word aligned
            default: begin
                data       = word;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback logic: selects the result, gates the
// register file write port, drives the forwarding bus and counts retirements.
module writeback_stage
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_load_word,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [XLEN-1:0]  mem_imm,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       writeRegister,
    output logic [XLEN-1:0]  writeData,
    output logic             regWrite,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             load_misaligned,
    output logic [CNT_W-1:0] retired_count
);

    logic             wb_valid_reg;
    logic [4:0]       wb_rd_reg;
    logic             wb_reg_write_reg;
    logic [1:0]       wb_sel_reg;
    logic [2:0]       wb_funct3_reg;
    logic [XLEN-1:0]  wb_alu_reg;
    logic [XLEN-1:0]  wb_load_word_reg;
    logic [XLEN-1:0]  wb_pc4_reg;
    logic [XLEN-1:0]  wb_imm_reg;
    logic [CNT_W-1:0] retired_count_reg;

    logic [XLEN-1:0]  load_data;
    logic             load_misaligned_raw;
    logic             live_write;
    logic             retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_reg     <= 1'b0;
            wb_rd_reg        <= '0;
            wb_reg_write_reg <= 1'b0;
            wb_sel_reg       <= WB_ALU;
            wb_funct3_reg    <= '0;
            wb_alu_reg       <= '0;
            wb_load_word_reg <= '0;
            wb_pc4_reg       <= '0;
            wb_imm_reg       <= '0;
        end else if (flush) begin
            // Killed slot: payload fields are left as-is, only validity drops.
            wb_valid_reg <= 1'b0;
        end else if (!stall) begin
            wb_valid_reg     <= mem_valid;
            wb_rd_reg        <= mem_rd;
            wb_reg_write_reg <= mem_reg_write;
            wb_sel_reg       <= mem_wb_sel;
            wb_funct3_reg    <= mem_funct3;
            wb_alu_reg       <= mem_alu_result;
            wb_load_word_reg <= mem_load_word;
            wb_pc4_reg       <= mem_pc_plus4;
            wb_imm_reg       <= mem_imm;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .word       (wb_load_word_reg),
        .offset     (wb_alu_reg[1:0]),
        .funct3     (wb_funct3_reg),
        .data       (load_data),
        .misaligned (load_misaligned_raw)
    );

    always_comb begin
        writeData = wb_alu_reg;
        case (wb_sel_reg)
            WB_LOAD: writeData = load_data;
            WB_PC4:  writeData = wb_pc4_reg;
            WB_IMM:  writeData = wb_imm_reg;
            default: writeData = wb_alu_reg;
        endcase
    end

    assign load_misaligned = wb_valid_reg & (wb_sel_reg == WB_LOAD) & load_misaligned_raw;

    // The register file does not guard x0, so rd==0 is filtered here.
    assign live_write    = wb_valid_reg & wb_reg_write_reg & (wb_rd_reg != 5'd0) & ~load_misaligned;
    assign regWrite      = live_write & ~stall;
    assign fwd_valid     = live_write;
    assign writeRegister = wb_rd_reg;
    assign fwd_rd        = wb_rd_reg;
    assign fwd_data      = writeData;

    assign retire = wb_valid_reg & ~stall & ~load_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count_reg <= '0;
        end else if (retire) begin
            retired_count_reg <= retired_count_reg + 1'b1;
        end
    end

    assign retired_count = retired_count_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: result paths, x0 guard, load extension,
// misalignment, stall/flush behaviour and asynchronous reset.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_word;
    logic [31:0] mem_pc_plus4;
    logic [31:0] mem_imm;
    logic        stall;
    logic        flush;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_misaligned;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_pass   = 0;
    int writes_x7 = 0;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_valid       (mem_valid),
        .mem_rd          (mem_rd),
        .mem_reg_write   (mem_reg_write),
        .mem_wb_sel      (mem_wb_sel),
        .mem_funct3      (mem_funct3),
        .mem_alu_result  (mem_alu_result),
        .mem_load_word   (mem_load_word),
        .mem_pc_plus4    (mem_pc_plus4),
        .mem_imm         (mem_imm),
        .stall           (stall),
        .flush           (flush),
        .writeRegister   (writeRegister),
        .writeData       (writeData),
        .regWrite        (regWrite),
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data),
        .load_misaligned (load_misaligned),
        .retired_count   (retired_count)
    );

    // Register-file view: a write to x7 commits on any edge with regWrite high.
    always @(posedge clk) begin
        if (rst_n && regWrite && writeRegister == 5'd7) writes_x7 <= writes_x7 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %-18s obs=0x%08h", tag, obs);
        end else begin
            $display("FAIL %-18s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu);
        mem_valid      = v;
        mem_rd         = rd;
        mem_reg_write  = we;
        mem_wb_sel     = sel;
        mem_funct3     = f3;
        mem_alu_result = alu;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        mem_load_word = 32'h807F_FF80;
        mem_pc_plus4  = 32'h0000_0104;
        mem_imm       = 32'h1234_5000;
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0);
        #12;
        check("rst_regWrite",  {31'b0, regWrite}, 32'd0);
        check("rst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
        check("rst_misalign",  {31'b0, load_misaligned}, 32'd0);
        check("rst_wreg",      {27'b0, writeRegister}, 32'd0);
        check("rst_wdata",     writeData, 32'd0);
        check("rst_count",     retired_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU result path
        drive(1'b1, 5'd5, 1'b1, 2'b00, 3'b010, 32'h0000_1234);
        tick();
        check("alu_regWrite",  {31'b0, regWrite}, 32'd1);
        check("alu_wreg",      {27'b0, writeRegister}, 32'd5);
        check("alu_wdata",     writeData, 32'h0000_1234);
        check("alu_fwd_valid", {31'b0, fwd_valid}, 32'd1);
        check("alu_fwd_rd",    {27'b0, fwd_rd}, 32'd5);
        check("alu_fwd_data",  fwd_data, 32'h0000_1234);
        check("alu_count0",    retired_count, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0);
        tick();
        check("alu_count1",    retired_count, 32'd1);

        // PC+4 and immediate sources
        drive(1'b1, 5'd1, 1'b1, 2'b10, 3'b010, 32'h0);
        tick();
        check("pc4_wdata",     writeData, 32'h0000_0104);
        drive(1'b1, 5'd2, 1'b1, 2'b11, 3'b010, 32'h0);
        tick();
        check("imm_wdata",     writeData, 32'h1234_5000);

        // x0 protection: no write, but it still retires
        drive(1'b1, 5'd0, 1'b1, 2'b00, 3'b010, 32'hFFFF_FFFF);
        tick();
        check("x0_regWrite",   {31'b0, regWrite}, 32'd0);
        check("x0_fwd_valid",  {31'b0, fwd_valid}, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0);
        tick();
        check("x0_count",      retired_count, 32'd4);

        // Load extension, word 0x807F_FF80
        drive(1'b1, 5'd3, 1'b1, 2'b01, 3'b000, 32'h0000_0100);
        tick();
        check("lb_wdata",      writeData, 32'hFFFF_FF80);
        drive(1'b1, 5'd3, 1'b1, 2'b01, 3'b100, 32'h0000_0100);
        tick();
        check("lbu_wdata",     writeData, 32'h0000_0080);
        drive(1'b1, 5'd3, 1'b1, 2'b01, 3'b001, 32'h0000_0102);
        tick();
        check("lh_wdata",      writeData, 32'hFFFF_807F);
        drive(1'b1, 5'd3, 1'b1, 2'b01, 3'b101, 32'h0000_0102);
        tick();
        check("lhu_wdata",     writeData, 32'h0000_807F);
        drive(1'b1, 5'd3, 1'b1, 2'b01, 3'b000, 32'h0000_0103);
        tick();
        check("lb3_wdata",     writeData, 32'hFFFF_FF80);
        drive(1'b1, 5'd3, 1'b1, 2'b01, 3'b100, 32'h0000_0101);
        tick();
        check("lbu1_wdata",    writeData, 32'h0000_00FF);
        drive(1'b1, 5'd3, 1'b1, 2'b01, 3'b010, 32'h0000_0100);
        tick();
        check("lw_wdata",      writeData, 32'h807F_FF80);
        check("lw_regWrite",   {31'b0, regWrite}, 32'd1);
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0);
        tick();
        check("load_count",    retired_count, 32'd11);

        // Misaligned loads: no write, no retire
        drive(1'b1, 5'd4, 1'b1, 2'b01, 3'b010, 32'h0000_0101);
        tick();
        check("mis_flag",      {31'b0, load_misaligned}, 32'd1);
        check("mis_regWrite",  {31'b0, regWrite}, 32'd0);
        check("mis_fwd_valid", {31'b0, fwd_valid}, 32'd0);
        drive(1'b1, 5'd4, 1'b1, 2'b01, 3'b001, 32'h0000_0103);
        tick();
        check("mis_lh_flag",   {31'b0, load_misaligned}, 32'd1);
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0);
        tick();
        check("mis_count",     retired_count, 32'd11);

        // Stall: held instruction forwards but writes only on release
        drive(1'b1, 5'd7, 1'b1, 2'b00, 3'b010, 32'h0000_0077);
        tick();
        stall = 1'b1;
        drive(1'b1, 5'd8, 1'b1, 2'b00, 3'b010, 32'h0000_0088);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stl_regWrite",  {31'b0, regWrite}, 32'd0);
            check("stl_fwd_valid", {31'b0, fwd_valid}, 32'd1);
            check("stl_wdata",     writeData, 32'h0000_0077);
            tick();
        end
        check("stl_wreg",      {27'b0, writeRegister}, 32'd7);
        check("stl_count",     retired_count, 32'd11);
        stall = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0);
        #1;
        check("rel_regWrite",  {31'b0, regWrite}, 32'd1);
        tick();
        check("rel_writes_x7", writes_x7, 32'd1);
        check("rel_count",     retired_count, 32'd12);

        // Flush and stall together: flush wins
        drive(1'b1, 5'd9, 1'b1, 2'b00, 3'b010, 32'h0000_0099);
        tick();
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0);
        #1;
        check("fl_regWrite",   {31'b0, regWrite}, 32'd0);
        check("fl_fwd_valid",  {31'b0, fwd_valid}, 32'd0);
        tick();
        check("fl_count",      retired_count, 32'd12);

        // Asynchronous reset between edges
        drive(1'b1, 5'd10, 1'b1, 2'b00, 3'b010, 32'h0000_00AA);
        tick();
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b010, 32'h0);
        check("ar_pre_regWrite", {31'b0, regWrite}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_regWrite",   {31'b0, regWrite}, 32'd0);
        check("ar_wdata",      writeData, 32'd0);
        check("ar_count",      retired_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
